// File: rtl/alu_host_pkg.sv
// Shared ALU op-codes, error byte and host FSM encoding.
// Imported by the host controller and by the ALU.
package alu_host_pkg;

  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h28;
  localparam logic [5:0] OP_SLTU = 6'h29;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_TX_RES,
    S_WAIT_RES,
    S_TX_FLAG,
    S_WAIT_FLAG
  } state_e;

  function automatic logic mode_ok(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    if (b[7:6] == 2'b00) begin
      unique case (b[5:0])
        OP_SLL, OP_SRL, OP_SRA,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU: ok = 1'b1;
        default:         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_host_if_if.sv
// UART/ALU side-band bundle of the ALU host controller.
// slave = the controller, master = UART + ALU side.
interface alu_host_if_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MODE_WIDTH = 6
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_done;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_alu_zero;
  logic [DATA_WIDTH-1:0] o_alu_A;
  logic [DATA_WIDTH-1:0] o_alu_B;
  logic [MODE_WIDTH-1:0] o_alu_mode;
  logic [7:0]            o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic                  o_timeout;

  modport master (
    output i_rx_data, i_rx_done, i_tx_done,
    output i_alu_result, i_alu_zero,
    input  o_alu_A, o_alu_B, o_alu_mode,
    input  o_tx_data, o_tx_start, o_busy, o_timeout
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done,
    input  i_alu_result, i_alu_zero,
    output o_alu_A, o_alu_B, o_alu_mode,
    output o_tx_data, o_tx_start, o_busy, o_timeout
  );
endinterface

// File: rtl/inter_byte_timer.sv
// Saturating idle counter between bytes of one command.
// expired is high while the count sits at CYCLES-1.
module inter_byte_timer #(
  parameter int unsigned CYCLES = 1000000,
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == LAST);
endmodule

// File: rtl/alu_host_if.sv
// UART command front-end for the ALU: takes A, B, MODE,
// answers with RESULT and FLAG (or a lone error byte).
module alu_host_if
  import alu_host_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MODE_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic         i_clk,
  input logic         i_reset,
  alu_host_if_if.slave bus
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  err_q, err_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  tmo_q, tmo_d;
  logic                  in_frame, expired;

  assign in_frame = (state_q == S_GET_B) ||
                    (state_q == S_GET_OP);

  inter_byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (!in_frame || bus.i_rx_done),
    .i_enable (in_frame),
    .o_expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    res_d      = res_q;
    zero_d     = zero_q;
    err_d      = err_q;
    tx_start_d = 1'b0;
    tmo_d      = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.i_rx_done) begin
        a_d     = DATA_WIDTH'(bus.i_rx_data);
        state_d = S_GET_B;
      end
      S_GET_B: if (bus.i_rx_done) begin
        b_d     = DATA_WIDTH'(bus.i_rx_data);
        state_d = S_GET_OP;
      end else if (expired) begin
        tmo_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_GET_OP: if (bus.i_rx_done) begin
        if (mode_ok(bus.i_rx_data))
          mode_d = bus.i_rx_data[MODE_WIDTH-1:0];
        else
          err_d = 1'b1;
        state_d = S_EXEC;
      end else if (expired) begin
        tmo_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_EXEC: begin
        res_d      = bus.i_alu_result;
        zero_d     = bus.i_alu_zero;
        tx_start_d = 1'b1;
        state_d    = S_TX_RES;
      end
      S_TX_RES: state_d = S_WAIT_RES;
      S_WAIT_RES: if (bus.i_tx_done) begin
        if (err_q) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          tx_start_d = 1'b1;
          state_d    = S_TX_FLAG;
        end
      end
      S_TX_FLAG: state_d = S_WAIT_FLAG;
      S_WAIT_FLAG: if (bus.i_tx_done) begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
    end
  end

  // Byte on the wire is a pure mux of held registers, so it stays put until tx_done.
  always_comb begin
    if (state_q == S_TX_FLAG || state_q == S_WAIT_FLAG)
      bus.o_tx_data = {7'b0, zero_q};
    else if (err_q)
      bus.o_tx_data = ERR_BYTE;
    else
      bus.o_tx_data = 8'(res_q);
  end

  assign bus.o_alu_A    = a_q;
  assign bus.o_alu_B    = b_q;
  assign bus.o_alu_mode = mode_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = tmo_q;
endmodule
